// File: rtl/mult_useq_pkg.sv
// Shared types, microcode addresses and the fixed microcode ROM for the shift-add multiplier sequencer.
package mult_useq_pkg;

    localparam int unsigned UPC_W = 5;
    localparam int unsigned CTL_W = 4;

    localparam int unsigned CTL_LD    = 3;
    localparam int unsigned CTL_ADD   = 2;
    localparam int unsigned CTL_SHIFT = 1;
    localparam int unsigned CTL_DONE  = 0;

    typedef logic [UPC_W-1:0] upc_t;

    // C_WAITLO loads unconditionally: hold while start is high, else jump to nxt
    typedef enum logic [2:0] {
        C_INCR   = 3'd0,
        C_ALWAYS = 3'd1,
        C_NSTART = 3'd2,
        C_NQ0    = 3'd3,
        C_NCNT   = 3'd4,
        C_WAITLO = 3'd5
    } cond_e;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        cond_e            cond;
        upc_t             nxt;
    } uword_t;

    localparam upc_t A_IDLE  = 5'd0;
    localparam upc_t A_LOAD  = 5'd1;
    localparam upc_t A_TEST  = 5'd2;
    localparam upc_t A_ADD   = 5'd3;
    localparam upc_t A_SHIFT = 5'd4;
    localparam upc_t A_DONE  = 5'd5;

    function automatic uword_t urom(input upc_t addr);
        uword_t uw;
        uw = '{ctl: 4'b0000, cond: C_ALWAYS, nxt: A_IDLE};
        case (addr)
            A_IDLE:  uw = '{ctl: 4'b0000, cond: C_NSTART, nxt: A_IDLE};
            A_LOAD:  uw = '{ctl: 4'b1000, cond: C_INCR,   nxt: A_IDLE};
            A_TEST:  uw = '{ctl: 4'b0000, cond: C_NQ0,    nxt: A_SHIFT};
            A_ADD:   uw = '{ctl: 4'b0100, cond: C_INCR,   nxt: A_IDLE};
            A_SHIFT: uw = '{ctl: 4'b0010, cond: C_NCNT,   nxt: A_TEST};
            A_DONE:  uw = '{ctl: 4'b0001, cond: C_WAITLO, nxt: A_IDLE};
            default: uw = '{ctl: 4'b0000, cond: C_ALWAYS, nxt: A_IDLE};
        endcase
        return uw;
    endfunction

endpackage

// File: rtl/mult_useq_ctrl_upcreg.sv
// Micro-PC register: loads upc_next when load_incr is set, otherwise increments.
module upcreg
    import mult_useq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_load_incr,
    input  upc_t i_upc_next,
    output upc_t o_upc
);

    upc_t r_upc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upc <= '0;
        end else if (i_load_incr) begin
            r_upc <= i_upc_next;
        end else begin
            r_upc <= r_upc + UPC_W'(1);
        end
    end

    assign o_upc = r_upc;

endmodule

// File: rtl/mult_useq_ctrl.sv
// Microcoded sequencer for the shift-add multiplier: branch evaluation, iteration count
// and decode of the current microword into datapath strobes and handshake.
module mult_useq_ctrl
    import mult_useq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_q0,
    output logic o_ld_ab,
    output logic o_clr_p,
    output logic o_add_en,
    output logic o_shift_en,
    output logic o_busy,
    output logic o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    upc_t             w_upc;
    uword_t           w_uw;
    logic             w_load_incr;
    upc_t             w_upc_next;
    logic             w_cnt_last;
    logic [CNT_W-1:0] r_cnt;

    upcreg u_upc (
        .clk         (clk),
        .reset       (reset),
        .i_load_incr (w_load_incr),
        .i_upc_next  (w_upc_next),
        .o_upc       (w_upc)
    );

    assign w_uw       = urom(w_upc);
    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Branch condition mux feeding the micro-PC
    always_comb begin
        w_load_incr = 1'b0;
        w_upc_next  = w_uw.nxt;
        case (w_uw.cond)
            C_INCR:   w_load_incr = 1'b0;
            C_ALWAYS: w_load_incr = 1'b1;
            C_NSTART: w_load_incr = !i_start;
            C_NQ0:    w_load_incr = !i_q0;
            C_NCNT:   w_load_incr = !w_cnt_last;
            C_WAITLO: begin
                w_load_incr = 1'b1;
                if (i_start) begin
                    w_upc_next = w_upc;
                end
            end
            default: begin
                w_load_incr = 1'b1;
                w_upc_next  = A_IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on operand load, advanced once per shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_uw.ctl[CTL_LD]) begin
            r_cnt <= '0;
        end else if (w_uw.ctl[CTL_SHIFT]) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_ld_ab    = w_uw.ctl[CTL_LD];
    assign o_clr_p    = w_uw.ctl[CTL_LD];
    assign o_add_en   = w_uw.ctl[CTL_ADD];
    assign o_shift_en = w_uw.ctl[CTL_SHIFT];
    assign o_done     = w_uw.ctl[CTL_DONE];
    assign o_busy     = (w_upc != A_IDLE);

endmodule
